vga_timing_gen: RTL and testbench
=================================

# vga_timing_gen

Parametrised VGA raster timing generator, successor to the fixed 640x480 controller. It produces pixel coordinates, sync, blank, and line/frame strobes for any mode set by parameters. It runs on the system clock with a pixel clock-enable instead of a separate VGA clock. Sync/blank can be delayed to match a downstream pixel pipeline, and an optional frame counter is provided. It sits between the clock-enable divider and the sprite/colour mapper feeding the video DAC.

## Interface

- H_ACTIVE, 640, visible pixels per line
- H_FP / H_SYNC / H_BP, 16 / 96 / 48, horizontal front porch / sync / back porch, in pixels
- V_ACTIVE, 480, visible lines
- V_FP / V_SYNC / V_BP, 10 / 2 / 33, vertical front porch / sync / back porch, in lines
- HS_POL / VS_POL, 0 / 0, asserted sync level (0 = active low)
- CW, 11, coordinate counter width; must hold H_TOTAL-1 and V_TOTAL-1
- PIPE, 0, sync/blank delay in PixEn ticks, 0..7

Ports:

- Clk  in  1  system clock
- Reset  in  1  synchronous, active-high
- PixEn  in  1  advance one pixel this cycle
- DrawX  out  CW  current horizontal count
- DrawY  out  CW  current vertical count
- VGA_HS  out  1  horizontal sync, polarity HS_POL
- VGA_VS  out  1  vertical sync, polarity VS_POL
- VGA_BLANK_N  out  1  high in the active region (after PIPE delay)
- VGA_SYNC_N  out  1  constant 0
- LineStart  out  1  one-Clk pulse when DrawX wraps to 0
- FrameStart  out  1  one-Clk pulse when (DrawX,DrawY) wraps to (0,0)
- FrameCount  out  16  frames completed, modulo 2^16

## Operation

- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise. Constants are computed at CW bits.
- On a PixEn cycle: DrawX increments. At H_TOTAL-1, DrawX goes to 0 and DrawY increments. At V_TOTAL-1, DrawY goes to 0.
- Without PixEn: all state holds, including the delay line.
- Decode is computed from next-counter values and registered together with the counters. At PIPE=0, VGA_* therefore corresponds to the DrawX/DrawY presented in the same cycle.
- HS asserted when H_ACTIVE+H_FP <= x < H_ACTIVE+H_FP+H_SYNC.
- VS asserted when V_ACTIVE+V_FP <= y < V_ACTIVE+V_FP+V_SYNC.
- BLANK_N high when x < H_ACTIVE and y < V_ACTIVE.
- For PIPE>0, the HS/VS/BLANK_N triple passes through a PIPE-stage shift register clocked on PixEn.
- LineStart / FrameStart:
  - High for exactly the one Clk cycle after the PixEn cycle that produced the wrap.
  - Not generated by Reset.
  - FrameStart implies LineStart in the same cycle.
- FrameCount increments, wrapping, in the same cycle FrameStart is asserted.

## Timing

- Reset values:
  - DrawX = DrawY = 0
  - VGA_HS = ~HS_POL, VGA_VS = ~VS_POL (deasserted)
  - VGA_BLANK_N = 0
  - LineStart = FrameStart = 0
  - FrameCount = 0
  - All delay stages hold the deasserted sync and blank values.
- Reset mid-frame: on the next cycle, all outputs take their reset values. The raster restarts at (0,0) on the following PixEn.
- Reset has priority over PixEn when both are asserted.
- Latency:
  - Coordinates: 1 Clk after the PixEn edge.
  - Sync/blank: PIPE further PixEn ticks.
- Full frame = H_TOTAL*V_TOTAL PixEn ticks.
- PixEn held high continuously: a 1-pixel-per-Clk raster, used for simulation speed.

## Configuration

- VGA_TIMING_FRAMECNT_EN defined: FrameCount register is present and behaves as described.
- Not defined: FrameCount is tied to 16'd0 and no counter logic is synthesised. FrameStart is unaffected.

## Structure

- Package vga_timing_pkg holds:
  - Default 640x480@60 constants (active, porch, sync values per axis).
  - An 800x600 constant set.
  - A packed struct vga_ctl_t {hs, vs, blank_n}.
- Sub-module vga_delay_line: a parametrised-depth, enable-gated shift register of vga_ctl_t with a reset value input. At PIPE=0 it is a pass-through.

## Test plan

- Defaults with PixEn=1 for 800*525 cycles:
  - VGA_HS asserted for x = 656..751 inclusive.
  - VGA_VS asserted for y = 490..491.
  - VGA_BLANK_N high for exactly 307200 cycles.
  - One FrameStart; FrameCount = 1.
- PixEn high 1 cycle in 2: every interval doubles. DrawX holds each value for 2 Clk cycles. LineStart is still 1 Clk wide.
- PIPE=3: VGA_HS first asserts 3 PixEn ticks after DrawX=656; BLANK_N falls 3 ticks after DrawX=640.
- Reset asserted at (x=300, y=200) for 1 cycle: next cycle DrawX=DrawY=0, VGA_BLANK_N=0, FrameCount=0, no FrameStart pulse.
- HS_POL=1, VS_POL=1, 800x600 package constants:
  - Sync is high-true.
  - H_TOTAL=1056, V_TOTAL=628.
  - DrawX wraps 1055 -> 0.
- Without VGA_TIMING_FRAMECNT_EN: run 3 frames; FrameCount stays 0 and FrameStart pulses 3 times.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: shared raster constants and control-bundle type for the
// VGA timing generator and its delay line.
package vga_timing_pkg;

   // 640x480@60 timing (default mode)
   localparam int DEF_H_ACTIVE = 640;
   localparam int DEF_H_FP     = 16;
   localparam int DEF_H_SYNC   = 96;
   localparam int DEF_H_BP     = 48;
   localparam int DEF_V_ACTIVE = 480;
   localparam int DEF_V_FP     = 10;
   localparam int DEF_V_SYNC   = 2;
   localparam int DEF_V_BP     = 33;

   // 800x600@60 timing
   localparam int SVGA_H_ACTIVE = 800;
   localparam int SVGA_H_FP     = 40;
   localparam int SVGA_H_SYNC   = 128;
   localparam int SVGA_H_BP     = 88;
   localparam int SVGA_V_ACTIVE = 600;
   localparam int SVGA_V_FP     = 1;
   localparam int SVGA_V_SYNC   = 4;
   localparam int SVGA_V_BP     = 23;

   typedef struct packed {
      logic hs;
      logic vs;
      logic blank_n;
   } vga_ctl_t;

   // True when v lies in the half-open window [lo, lo+len)
   function automatic logic in_span(input int v, input int lo, input int len);
      return (v >= lo) && (v < lo + len);
   endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// vga_timing_gen_if: raster outputs of the timing generator. The generator
// drives through the master modport; the colour mapper reads via slave.
interface vga_timing_gen_if #(
   parameter int CW = 11
);
   logic [CW-1:0] DrawX;
   logic [CW-1:0] DrawY;
   logic          VGA_HS;
   logic          VGA_VS;
   logic          VGA_BLANK_N;
   logic          VGA_SYNC_N;
   logic          LineStart;
   logic          FrameStart;
   logic [15:0]   FrameCount;

   modport master (
      output DrawX, DrawY, VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N,
             LineStart, FrameStart, FrameCount
   );

   modport slave (
      input  DrawX, DrawY, VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N,
             LineStart, FrameStart, FrameCount
   );
endinterface

// File: rtl/vga_delay_line.sv
// vga_delay_line: enable-gated shift register for the hs/vs/blank_n bundle,
// used to line sync/blank up with a downstream pixel pipeline. DEPTH=0 is a
// straight pass-through.
module vga_delay_line
   import vga_timing_pkg::*;
#(
   parameter int DEPTH = 0
) (
   input  logic     Clk,
   input  logic     Reset,
   input  logic     en,
   input  vga_ctl_t rst_val,
   input  vga_ctl_t din,
   output vga_ctl_t dout
);

   generate
      if (DEPTH == 0) begin : g_pass
         logic unused_ok;
         assign unused_ok = ^{Clk, Reset, en, rst_val};
         assign dout      = din;
      end else begin : g_shift
         vga_ctl_t sr_p1 [DEPTH];

         // Shift one stage per pixel tick; reset loads the idle bundle
         always_ff @(posedge Clk) begin
            if (Reset) begin
               for (int i = 0; i < DEPTH; i++) sr_p1[i] <= rst_val;
            end else if (en) begin
               sr_p1[0] <= din;
               for (int i = 1; i < DEPTH; i++) sr_p1[i] <= sr_p1[i-1];
            end
         end

         assign dout = sr_p1[DEPTH-1];
      end
   endgenerate

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA raster timing generator running on the
// system clock with a pixel clock-enable. Optional frame counter is built
// when VGA_TIMING_FRAMECNT_EN is defined; otherwise FrameCount reads 0.
module vga_timing_gen
   import vga_timing_pkg::*;
#(
   parameter int H_ACTIVE = DEF_H_ACTIVE,
   parameter int H_FP     = DEF_H_FP,
   parameter int H_SYNC   = DEF_H_SYNC,
   parameter int H_BP     = DEF_H_BP,
   parameter int V_ACTIVE = DEF_V_ACTIVE,
   parameter int V_FP     = DEF_V_FP,
   parameter int V_SYNC   = DEF_V_SYNC,
   parameter int V_BP     = DEF_V_BP,
   parameter bit HS_POL   = 1'b0,
   parameter bit VS_POL   = 1'b0,
   parameter int CW       = 11,
   parameter int PIPE     = 0
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             PixEn,
   vga_timing_gen_if.master vid
);

   localparam logic [CW-1:0] H_LAST = CW'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
   localparam logic [CW-1:0] V_LAST = CW'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
   localparam vga_ctl_t CTL_IDLE = '{hs: ~HS_POL, vs: ~VS_POL, blank_n: 1'b0};

   logic [CW-1:0] x_p0, y_p0;
   logic [CW-1:0] x_nxt, y_nxt;
   logic          wrap_line, wrap_frame;
   logic          line_p0, frame_p0;
   vga_ctl_t      ctl_nxt, ctl_p0, ctl_out;

   // Next raster position and the sync/blank decode of that position
   always_comb begin
      x_nxt      = x_p0;
      y_nxt      = y_p0;
      wrap_line  = 1'b0;
      wrap_frame = 1'b0;
      if (PixEn) begin
         if (x_p0 == H_LAST) begin
            x_nxt     = '0;
            wrap_line = 1'b1;
            if (y_p0 == V_LAST) begin
               y_nxt      = '0;
               wrap_frame = 1'b1;
            end else begin
               y_nxt = y_p0 + CW'(1);
            end
         end else begin
            x_nxt = x_p0 + CW'(1);
         end
      end
      ctl_nxt.hs      = in_span(int'(x_nxt), H_ACTIVE + H_FP, H_SYNC) ? HS_POL : ~HS_POL;
      ctl_nxt.vs      = in_span(int'(y_nxt), V_ACTIVE + V_FP, V_SYNC) ? VS_POL : ~VS_POL;
      ctl_nxt.blank_n = (int'(x_nxt) < H_ACTIVE) && (int'(y_nxt) < V_ACTIVE);
   end

   // Stage p0: counters and decoded controls advance together on PixEn
   always_ff @(posedge Clk) begin
      if (Reset) begin
         x_p0   <= '0;
         y_p0   <= '0;
         ctl_p0 <= CTL_IDLE;
      end else if (PixEn) begin
         x_p0   <= x_nxt;
         y_p0   <= y_nxt;
         ctl_p0 <= ctl_nxt;
      end
   end

   // Line/frame strobes: one Clk wide, only from a real wrap, never from reset
   always_ff @(posedge Clk) begin
      if (Reset) begin
         line_p0  <= 1'b0;
         frame_p0 <= 1'b0;
      end else begin
         line_p0  <= wrap_line;
         frame_p0 <= wrap_frame;
      end
   end

   vga_delay_line #(
      .DEPTH (PIPE)
   ) u_dly (
      .Clk     (Clk),
      .Reset   (Reset),
      .en      (PixEn),
      .rst_val (CTL_IDLE),
      .din     (ctl_p0),
      .dout    (ctl_out)
   );

`ifdef VGA_TIMING_FRAMECNT_EN
   logic [15:0] fcnt_p0;

   // Completed-frame count, stepping on the same edge that raises FrameStart
   always_ff @(posedge Clk) begin
      if (Reset)           fcnt_p0 <= '0;
      else if (wrap_frame) fcnt_p0 <= fcnt_p0 + 16'd1;
   end

   assign vid.FrameCount = fcnt_p0;
`else
   assign vid.FrameCount = 16'd0;
`endif

   assign vid.DrawX       = x_p0;
   assign vid.DrawY       = y_p0;
   assign vid.VGA_HS      = ctl_out.hs;
   assign vid.VGA_VS      = ctl_out.vs;
   assign vid.VGA_BLANK_N = ctl_out.blank_n;
   assign vid.VGA_SYNC_N  = 1'b0;
   assign vid.LineStart   = line_p0;
   assign vid.FrameStart  = frame_p0;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: four generator instances (640x480, 800x600 high-true
// sync, and a tiny mode at PIPE=3 and PIPE=0) share one Clk/Reset/PixEn.
// Expected outputs come from the count of pixel ticks since reset.
module tb_vga_timing_gen;
   import vga_timing_pkg::*;

`ifdef VGA_TIMING_FRAMECNT_EN
   localparam bit FC_EN = 1'b1;
`else
   localparam bit FC_EN = 1'b0;
`endif

   localparam int NCYC = 36000;

   typedef struct {
      int ha, hfp, hsy, hbp;
      int va, vfp, vsy, vbp;
      bit hpol, vpol;
      int pipe;
   } mode_t;

   logic Clk;
   logic Reset;
   logic PixEn;

   int   n_vec;
   int   n_err;
   int   t;
   bit   ticked;

   mode_t m_def, m_svga, m_sm3, m_sm0;

   vga_timing_gen_if #(.CW(11)) if_def  ();
   vga_timing_gen_if #(.CW(11)) if_svga ();
   vga_timing_gen_if #(.CW(5))  if_sm3  ();
   vga_timing_gen_if #(.CW(6))  if_sm0  ();

   vga_timing_gen u_def (
      .Clk   (Clk),
      .Reset (Reset),
      .PixEn (PixEn),
      .vid   (if_def)
   );

   vga_timing_gen #(
      .H_ACTIVE (SVGA_H_ACTIVE), .H_FP (SVGA_H_FP), .H_SYNC (SVGA_H_SYNC), .H_BP (SVGA_H_BP),
      .V_ACTIVE (SVGA_V_ACTIVE), .V_FP (SVGA_V_FP), .V_SYNC (SVGA_V_SYNC), .V_BP (SVGA_V_BP),
      .HS_POL (1'b1), .VS_POL (1'b1), .CW (11), .PIPE (0)
   ) u_svga (
      .Clk   (Clk),
      .Reset (Reset),
      .PixEn (PixEn),
      .vid   (if_svga)
   );

   vga_timing_gen #(
      .H_ACTIVE (16), .H_FP (2), .H_SYNC (3), .H_BP (4),
      .V_ACTIVE (8),  .V_FP (1), .V_SYNC (2), .V_BP (3),
      .HS_POL (1'b0), .VS_POL (1'b1), .CW (5), .PIPE (3)
   ) u_sm3 (
      .Clk   (Clk),
      .Reset (Reset),
      .PixEn (PixEn),
      .vid   (if_sm3)
   );

   vga_timing_gen #(
      .H_ACTIVE (16), .H_FP (2), .H_SYNC (3), .H_BP (4),
      .V_ACTIVE (8),  .V_FP (1), .V_SYNC (2), .V_BP (3),
      .HS_POL (1'b1), .VS_POL (1'b0), .CW (6), .PIPE (0)
   ) u_sm0 (
      .Clk   (Clk),
      .Reset (Reset),
      .PixEn (PixEn),
      .vid   (if_sm0)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, want %0h (t=%0d, time %0t)", tag, act, exp, t, $time);
      end
   endtask

   // Expected outputs from the tick count alone: position is t mod line/frame
   // length, sync/blank reflect the position PIPE ticks earlier.
   task automatic check_dut(input string nm, input mode_t m,
                            input logic [15:0] x, input logic [15:0] y,
                            input logic hs, input logic vs, input logic bn,
                            input logic sn, input logic ls, input logic fs,
                            input logic [15:0] fc);
      int ht, vt, ft, tt, px, py;
      bit e_hs, e_vs, e_bn;
      ht = m.ha + m.hfp + m.hsy + m.hbp;
      vt = m.va + m.vfp + m.vsy + m.vbp;
      ft = ht * vt;
      tt = t - m.pipe;
      e_hs = !m.hpol;
      e_vs = !m.vpol;
      e_bn = 1'b0;
      if (tt >= 1) begin
         px = tt % ht;
         py = (tt / ht) % vt;
         if (px >= m.ha + m.hfp && px < m.ha + m.hfp + m.hsy) e_hs = m.hpol;
         if (py >= m.va + m.vfp && py < m.va + m.vfp + m.vsy) e_vs = m.vpol;
         e_bn = (px < m.ha) && (py < m.va);
      end
      check({nm, ".DrawX"},       32'(x),  32'(t % ht));
      check({nm, ".DrawY"},       32'(y),  32'((t / ht) % vt));
      check({nm, ".VGA_HS"},      32'(hs), 32'(e_hs));
      check({nm, ".VGA_VS"},      32'(vs), 32'(e_vs));
      check({nm, ".VGA_BLANK_N"}, 32'(bn), 32'(e_bn));
      check({nm, ".VGA_SYNC_N"},  32'(sn), 32'd0);
      check({nm, ".LineStart"},   32'(ls), 32'(ticked && (t % ht == 0)));
      check({nm, ".FrameStart"},  32'(fs), 32'(ticked && (t % ft == 0)));
      check({nm, ".FrameCount"},  32'(fc), FC_EN ? 32'((t / ft) % 65536) : 32'd0);
   endtask

   task automatic step_model(input logic rst, input logic pix);
      if (rst) begin
         t      = 0;
         ticked = 1'b0;
      end else if (pix) begin
         t      = t + 1;
         ticked = 1'b1;
      end else begin
         ticked = 1'b0;
      end
   endtask

   initial begin
      logic rst_n, pix_n;
      n_vec  = 0;
      n_err  = 0;
      t      = 0;
      ticked = 1'b0;

      m_def  = '{ha: DEF_H_ACTIVE, hfp: DEF_H_FP, hsy: DEF_H_SYNC, hbp: DEF_H_BP,
                 va: DEF_V_ACTIVE, vfp: DEF_V_FP, vsy: DEF_V_SYNC, vbp: DEF_V_BP,
                 hpol: 1'b0, vpol: 1'b0, pipe: 0};
      m_svga = '{ha: SVGA_H_ACTIVE, hfp: SVGA_H_FP, hsy: SVGA_H_SYNC, hbp: SVGA_H_BP,
                 va: SVGA_V_ACTIVE, vfp: SVGA_V_FP, vsy: SVGA_V_SYNC, vbp: SVGA_V_BP,
                 hpol: 1'b1, vpol: 1'b1, pipe: 0};
      m_sm3  = '{ha: 16, hfp: 2, hsy: 3, hbp: 4, va: 8, vfp: 1, vsy: 2, vbp: 3,
                 hpol: 1'b0, vpol: 1'b1, pipe: 3};
      m_sm0  = '{ha: 16, hfp: 2, hsy: 3, hbp: 4, va: 8, vfp: 1, vsy: 2, vbp: 3,
                 hpol: 1'b1, vpol: 1'b0, pipe: 0};

      Reset = 1'b1;
      PixEn = 1'b1;
      step_model(Reset, PixEn);

      for (int c = 0; c < NCYC; c++) begin
         @(negedge Clk);
         check_dut("def", m_def, 16'(if_def.DrawX), 16'(if_def.DrawY),
                   if_def.VGA_HS, if_def.VGA_VS, if_def.VGA_BLANK_N, if_def.VGA_SYNC_N,
                   if_def.LineStart, if_def.FrameStart, if_def.FrameCount);
         check_dut("svga", m_svga, 16'(if_svga.DrawX), 16'(if_svga.DrawY),
                   if_svga.VGA_HS, if_svga.VGA_VS, if_svga.VGA_BLANK_N, if_svga.VGA_SYNC_N,
                   if_svga.LineStart, if_svga.FrameStart, if_svga.FrameCount);
         check_dut("sm3", m_sm3, 16'(if_sm3.DrawX), 16'(if_sm3.DrawY),
                   if_sm3.VGA_HS, if_sm3.VGA_VS, if_sm3.VGA_BLANK_N, if_sm3.VGA_SYNC_N,
                   if_sm3.LineStart, if_sm3.FrameStart, if_sm3.FrameCount);
         check_dut("sm0", m_sm0, 16'(if_sm0.DrawX), 16'(if_sm0.DrawY),
                   if_sm0.VGA_HS, if_sm0.VGA_VS, if_sm0.VGA_BLANK_N, if_sm0.VGA_SYNC_N,
                   if_sm0.LineStart, if_sm0.FrameStart, if_sm0.FrameCount);

         // Phases: reset, continuous raster (with one mid-frame reset while
         // PixEn is high), 1-in-2 enable, then random enable with rare resets.
         rst_n = (c < 3) || (c == 17000) ||
                 (c >= 24000 && $urandom_range(0, 1999) == 0);
         if (c < 3)          pix_n = 1'($urandom_range(0, 1));
         else if (c < 20000) pix_n = 1'b1;
         else if (c < 24000) pix_n = 1'(c % 2);
         else                pix_n = ($urandom_range(0, 3) != 0);

         Reset = rst_n;
         PixEn = pix_n;
         step_model(rst_n, pix_n);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
